uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, line bit rate; bit period L = CLK_HZ/BAUD clocks, half period HL = L/2.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9.
REQ-004 Parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 Port clk, input, 1, sole clock; all logic on rising edge; one clock; reset is asynchronous and active-high.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port rxd, input, 1, asynchronous serial line, idle high.
REQ-009 Port m_data, output, DATA_BITS, received word, LSB = first data bit on line.
REQ-010 Port m_perr, output, 1, parity error for the word on m_data; 0 when PARITY = 0.
REQ-011 Port m_ferr, output, 1, framing error (any stop bit sampled 0) for the word on m_data.
REQ-012 Port m_valid, output, 1, m_data/m_perr/m_ferr valid.
REQ-013 Port m_ready, input, 1, consumer accepts the word when m_valid and m_ready are both high on a clock edge.
REQ-014 Port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-015 Port busy, output, 1, high in every state except IDLE.

Function
REQ-016 rxd passes through a two-flop synchroniser; all decisions use the synchronised value rxs.
REQ-017 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 IDLE -> START when rxs = 0; the bit-period counter clears to 0 on entry.
REQ-019 Bit-period counter counts 0..L-1 and wraps; each bit's sample point is count = HL.
REQ-020 START: sample = 1 at HL -> IDLE (false start, no output); sample = 0 -> DATA at the wrap.
REQ-021 DATA: DATA_BITS samples, LSB first; after the last sample and wrap -> PARITY if PARITY != 0, else STOP.
REQ-022 PARITY: even mode flags m_perr when XOR(data, parity bit) = 1; odd mode flags m_perr when it = 0.
REQ-023 STOP: STOP_BITS samples; after the final stop-bit sample, frame completes in that same cycle (no wait for the wrap); -> IDLE if the final stop-bit sample is 1, else -> BREAK.
REQ-024 BREAK -> IDLE once rxs = 1.
REQ-025 On frame completion with m_valid = 0, or with m_valid = 1 and m_ready = 1 in the same cycle: m_data/m_perr/m_ferr load and m_valid = 1 in the next cycle.
REQ-026 On frame completion with m_valid = 1 and m_ready = 0: new frame discarded, held word unchanged, overrun = 1 for exactly one cycle.
REQ-027 m_valid clears on handshake unless a frame completes in that same cycle (REQ-025).
REQ-028 Output word and flags are stable while m_valid = 1 and m_ready = 0.

Reset
REQ-029 rst asynchronously forces state IDLE, counters 0, synchroniser flops 1, m_data 0, m_perr 0, m_ferr 0, m_valid 0, overrun 0, busy 0.
REQ-030 rst mid-frame discards the partial frame; reception restarts at the next start bit after release.

Configuration
REQ-031 With macro UART_RX_MAJORITY_EN defined, each bit value is the 2-of-3 majority of rxs at counts HL-1, HL and HL+1; the decision uses the HL+1 sample.
REQ-032 Without UART_RX_MAJORITY_EN, each bit value is the single rxs sample at count HL; no extra sample registers are built.

Structure
REQ-033 Package uart_pkg holds the state enum, the parity-mode constants (NONE/EVEN/ODD) and the bit-period and counter-width calculation.
REQ-034 Sub-module uart_bit_timer holds the bit-period counter; it has clear, mid-bit-strobe and wrap-strobe ports.

Verification
REQ-035 8N1 byte 0xA5 -> m_data = 0xA5, m_perr = 0, m_ferr = 0, m_valid high until m_ready.
REQ-036 PARITY = 2, DATA_BITS = 7, word 0x55 sent with wrong parity bit -> m_data = 0x55, m_perr = 1.
REQ-037 Stop bit held low for 3 bit periods -> m_ferr = 1, busy stays high until rxd is high again, then the next frame 0x3C is received cleanly.
REQ-038 m_ready held low, two frames 0x11 then 0x22 -> m_data stays 0x11, single-cycle overrun pulse.
REQ-039 Low glitch of HL-2 clocks on idle line -> false start, returns to IDLE, no m_valid.
REQ-040 rst asserted mid-DATA -> all outputs 0; a frame of 0x7E after release is received correctly; repeat REQ-035 with UART_RX_MAJORITY_EN and a single-clock glitch at HL flipping one data bit -> still 0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, parity-mode constants and bit-timing helpers
package uart_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    function automatic int bit_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
    function automatic int cnt_width(input int l);
        return (l > 2) ? $clog2(l) : 1;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter 0..L-1 with mid-bit and wrap strobes
//   clk, rst : clock, asynchronous active-high reset
//   clr      : forces the count to 0 (held while the receiver is idle)
//   mid      : high while count = L/2
//   wrap     : high while count = L-1
module uart_bit_timer #(
    parameter int L  = 434,
    parameter int CW = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic mid,
    output logic wrap
);
    localparam logic [CW-1:0] LAST = CW'(L - 1);
    localparam logic [CW-1:0] HALF = CW'(L / 2);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (clr || cnt == LAST) ? '0 : cnt + 1'b1;
    assign mid  = cnt == HALF;
    assign wrap = cnt == LAST;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with ready/valid output, parity/framing flags, overrun pulse
//   rxd                  : asynchronous serial input, idle high
//   m_data/m_perr/m_ferr : received word, parity error, framing error
//   m_valid/m_ready      : output handshake; a frame completing while a word is held is dropped (overrun)
//   busy                 : high whenever the receiver is not idle
//   UART_RX_MAJORITY_EN  : when defined, bits are a 2-of-3 vote around mid-bit, decided one clock later
module uart_rx_cfg #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 busy
);
    import uart_pkg::*;
    localparam int L  = bit_period(CLK_HZ, BAUD);
    localparam int CW = cnt_width(L);
    state_t state, nstate;
    logic [1:0] sync;
    logic rxs, mid, wrap, tclr, stb, bv, done, pbit, ferr_acc, frame_perr;
    logic [3:0] bcnt;
    logic [DATA_BITS-1:0] shreg;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= 2'b11;
        else sync <= {sync[0], rxd};
    assign rxs = sync[1];
    uart_bit_timer #(.L(L), .CW(CW)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tclr),
        .mid (mid),
        .wrap(wrap)
    );
`ifdef UART_RX_MAJORITY_EN
    // hist holds rxs from the two previous clocks, so one clock after mid it
    // carries the HL-1 and HL samples while rxs itself is the HL+1 sample.
    logic [1:0] hist;
    logic mid_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hist  <= 2'b11;
            mid_d <= 1'b0;
        end else begin
            hist  <= {hist[0], rxs};
            mid_d <= mid;
        end
    assign stb = mid_d;
    assign bv  = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
    assign stb = mid;
    assign bv  = rxs;
`endif
    assign done = state == S_STOP && stb && bcnt == 4'(STOP_BITS - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= nstate;
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:   nstate = rxs ? S_IDLE : S_START;
            S_START:  nstate = (stb && bv) ? S_IDLE : (wrap ? S_DATA : S_START);
            S_DATA:   nstate = (wrap && bcnt == 4'(DATA_BITS)) ? ((PARITY != PAR_NONE) ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: nstate = wrap ? S_STOP : S_PARITY;
            S_STOP:   nstate = done ? (bv ? S_IDLE : S_BREAK) : S_STOP;
            S_BREAK:  nstate = rxs ? S_IDLE : S_BREAK;
            default:  nstate = S_IDLE;
        endcase
    end
    always_comb begin
        busy = state != S_IDLE;
        tclr = state == S_IDLE;
    end
    // bcnt counts samples within DATA and STOP and restarts on every state change
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bcnt     <= '0;
            shreg    <= '0;
            pbit     <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            bcnt     <= (nstate != state) ? '0 : ((stb && (state == S_DATA || state == S_STOP)) ? bcnt + 1'b1 : bcnt);
            shreg    <= (stb && state == S_DATA) ? {bv, shreg[DATA_BITS-1:1]} : shreg;
            pbit     <= (stb && state == S_PARITY) ? bv : pbit;
            ferr_acc <= (state == S_IDLE) ? 1'b0 : (ferr_acc | (stb && state == S_STOP && !bv));
        end
    assign frame_perr = (PARITY == PAR_NONE) ? 1'b0 : ((^shreg) ^ pbit ^ (PARITY == PAR_ODD));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            m_data  <= '0;
            m_perr  <= 1'b0;
            m_ferr  <= 1'b0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= done && m_valid && !m_ready;
            if (done && (!m_valid || m_ready)) begin
                m_data  <= shreg;
                m_perr  <= frame_perr;
                m_ferr  <= ferr_acc | ~bv;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg (8N1 and 7O2 instances, 16 clocks per bit)
module tb_uart_rx_cfg;
    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int L      = 16;
    localparam int HL     = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rdy0 = 1'b1, rx1 = 1'b1, rdy1 = 1'b1;
    logic [7:0] d0;
    logic [6:0] d1;
    logic pe0, fe0, v0, ov0, bz0, pe1, fe1, v1, ov1, bz1;
    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u0 (
        .clk(clk), .rst(rst), .rxd(rx0), .m_data(d0), .m_perr(pe0), .m_ferr(fe0),
        .m_valid(v0), .m_ready(rdy0), .overrun(ov0), .busy(bz0)
    );
    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .rxd(rx1), .m_data(d1), .m_perr(pe1), .m_ferr(fe1),
        .m_valid(v1), .m_ready(rdy1), .overrun(ov1), .busy(bz1)
    );

    typedef struct {logic [8:0] d; logic pe; logic fe;} exp_t;
    typedef struct {int u; logic [8:0] d; logic bad_par; logic [1:0] stops; logic [8:0] ed; logic epe; logic efe;} vec_t;
    exp_t q0[$], q1[$];
    vec_t vt[9];
    int total = 0, bad = 0, ov0_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    exp_t e0, e1;
    always @(negedge clk) begin
        if (ov0) ov0_cnt++;
        if (!rst && v0 && rdy0) begin
            if (q0.size() == 0) check("u0 unexpected word", {23'd0, v0, d0}, 0);
            else begin
                e0 = q0.pop_front();
                check("u0 data", d0, e0.d);
                check("u0 perr", pe0, e0.pe);
                check("u0 ferr", fe0, e0.fe);
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && v1 && rdy1) begin
            if (q1.size() == 0) check("u1 unexpected word", {24'd0, v1, d1}, 0);
            else begin
                e1 = q1.pop_front();
                check("u1 data", d1, e1.d);
                check("u1 perr", pe1, e1.pe);
                check("u1 ferr", fe1, e1.fe);
            end
        end
    end

    task automatic drive(input int u, input logic v);
        if (u == 0) rx0 = v;
        else rx1 = v;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic bit_out(input int u, input logic v);
        drive(u, v);
        idle(L);
    endtask
    // start bit, data LSB first and (for u1) odd parity, optionally corrupted
    task automatic send_body(input int u, input logic [8:0] d, input logic bad_par);
        int nb = (u == 0) ? 8 : 7;
        logic p = 1'b0;
        bit_out(u, 1'b0);
        for (int i = 0; i < nb; i++) begin
            bit_out(u, d[i]);
            p ^= d[i];
        end
        if (u == 1) bit_out(u, ~p ^ bad_par);
    endtask
    task automatic send(input int u, input logic [8:0] d, input logic bad_par, input logic [1:0] stops);
        send_body(u, d, bad_par);
        bit_out(u, stops[0]);
        if (u == 1) bit_out(u, stops[1]);
        drive(u, 1'b1);
    endtask
    task automatic check_u0_zero(input string tag);
        check({tag, " m_data"}, d0, 0);
        check({tag, " m_perr"}, pe0, 0);
        check({tag, " m_ferr"}, fe0, 0);
        check({tag, " m_valid"}, v0, 0);
        check({tag, " overrun"}, ov0, 0);
        check({tag, " busy"}, bz0, 0);
    endtask

    initial begin
        vt[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vt[1] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vt[2] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        vt[3] = '{0, 9'h05A, 1'b0, 2'b10, 9'h05A, 1'b0, 1'b1};
        vt[4] = '{1, 9'h055, 1'b1, 2'b11, 9'h055, 1'b1, 1'b0};
        vt[5] = '{1, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
        vt[6] = '{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
        vt[7] = '{1, 9'h02A, 1'b0, 2'b10, 9'h02A, 1'b0, 1'b1};
        vt[8] = '{1, 9'h001, 1'b0, 2'b01, 9'h001, 1'b0, 1'b1};
        #22;
        check_u0_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(L);
        for (int i = 0; i < 9; i++) begin
            if (vt[i].u == 0) q0.push_back('{vt[i].ed, vt[i].epe, vt[i].efe});
            else q1.push_back('{vt[i].ed, vt[i].epe, vt[i].efe});
            send(vt[i].u, vt[i].d, vt[i].bad_par, vt[i].stops);
            idle(2 * L);
        end
        // stop bit held low for three bit periods, then a clean frame
        q0.push_back('{9'h081, 1'b0, 1'b1});
        send_body(0, 9'h081, 1'b0);
        drive(0, 1'b0);
        idle(3 * L);
        check("break busy", bz0, 1);
        drive(0, 1'b1);
        idle(L);
        check("break released busy", bz0, 0);
        q0.push_back('{9'h03C, 1'b0, 1'b0});
        send(0, 9'h03C, 1'b0, 2'b11);
        idle(2 * L);
        // overrun: second frame dropped while first is held
        rdy0 = 1'b0;
        ov0_cnt = 0;
        q0.push_back('{9'h011, 1'b0, 1'b0});
        send(0, 9'h011, 1'b0, 2'b11);
        idle(L);
        send(0, 9'h022, 1'b0, 2'b11);
        idle(L);
        check("overrun held data", d0, 8'h11);
        check("overrun held valid", v0, 1);
        check("overrun pulse cycles", ov0_cnt, 1);
        rdy0 = 1'b1;
        idle(4);
        check("valid cleared after handshake", v0, 0);
        // short glitch is a false start
        drive(0, 1'b0);
        idle(5);
        check("glitch busy", bz0, 1);
        idle(HL - 2 - 5);
        drive(0, 1'b1);
        idle(2 * L);
        check("glitch busy cleared", bz0, 0);
        check("glitch no valid", v0, 0);
        // reset mid-DATA discards the partial frame
        bit_out(0, 1'b0);
        bit_out(0, 1'b1);
        bit_out(0, 1'b0);
        bit_out(0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_u0_zero("mid-frame reset");
        drive(0, 1'b1);
        idle(2);
        rst = 1'b0;
        idle(L);
        q0.push_back('{9'h07E, 1'b0, 1'b0});
        send(0, 9'h07E, 1'b0, 2'b11);
        idle(2 * L);
`ifdef UART_RX_MAJORITY_EN
        // one-clock glitch landing on the mid-bit sample of data bit 2
        q0.push_back('{9'h0A5, 1'b0, 1'b0});
        bit_out(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                drive(0, 1'b1);
                idle(HL);
                drive(0, 1'b0);
                idle(1);
                drive(0, 1'b1);
                idle(L - HL - 1);
            end else bit_out(0, (8'hA5 >> i) & 8'h01);
        end
        bit_out(0, 1'b1);
        idle(2 * L);
`endif
        for (int i = 0; i < 500 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        check("words still pending", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
